// File: rtl/gon_pkg.sv
// Shared default widths and sizes for the global output network buses.
package gon_pkg;
    localparam int ROW_LEN   = 4;
    localparam int COL_LEN   = 5;
    localparam int VALUE_LEN = 32;
    localparam int XBUS_NUMS = 12;
    localparam int PE_NUMS   = 14;

    // Width of a slave-side tag: {ready, id_field, sub_field}.
    function automatic int gon_tag_width(input int id_len, input int sub_len);
        return id_len + sub_len + 1;
    endfunction
endpackage

// File: rtl/gon_id_chain.sv
// Scan-loaded per-master ID registers and their comparators against the tag's id field.
module gon_id_chain #(
    parameter int MASTER_NUMS = 14,
    parameter int ID_LEN      = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_id,
    input  logic [ID_LEN-1:0]      id_scan_in,
    input  logic [ID_LEN-1:0]      id_field,
    output logic [ID_LEN-1:0]      id_scan_out,
    output logic [MASTER_NUMS-1:0] match
);
    logic [ID_LEN-1:0] id_q [MASTER_NUMS];
    logic [ID_LEN-1:0] id_d [MASTER_NUMS];

    generate
        for (genvar gi = 0; gi < MASTER_NUMS; gi++) begin : g_id
            if (gi == 0) begin : g_head
                assign id_d[gi] = set_id ? id_scan_in : id_q[gi];
            end else begin : g_body
                assign id_d[gi] = set_id ? id_q[gi-1] : id_q[gi];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    id_q[gi] <= '0;
                end else begin
                    id_q[gi] <= id_d[gi];
                end
            end

            assign match[gi] = (id_q[gi] == id_field);
        end
    endgenerate

    assign id_scan_out = id_q[MASTER_NUMS-1];
endmodule

// File: rtl/gon_bus.sv
// One GON bus level: tag-matched ready fan-out to masters and lowest-index response gather.
module gon_bus
    import gon_pkg::*;
#(
    parameter int MASTER_NUMS = gon_pkg::PE_NUMS,
    parameter int ID_LEN      = gon_pkg::COL_LEN,
    parameter int SUB_LEN     = 0,
    parameter int VALUE_LEN   = gon_pkg::VALUE_LEN,
    parameter int MA_Y        = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [ID_LEN+SUB_LEN:0]               ready_tag,
    output logic [VALUE_LEN:0]                    enable_value,
    output logic [MASTER_NUMS-1:0][SUB_LEN:0]     master_ready_tag,
    input  logic [MASTER_NUMS-1:0][VALUE_LEN:0]   master_enable_data,
    input  logic                                  set_id,
    input  logic [ID_LEN-1:0]                     id_scan_in,
    output logic [ID_LEN-1:0]                     id_scan_out
);
    localparam int TAG_W = gon_tag_width(ID_LEN, SUB_LEN);

    logic                   ready;
    logic [ID_LEN-1:0]      id_field;
    logic [MASTER_NUMS-1:0] match;

    assign ready    = ready_tag[TAG_W-1];
    assign id_field = ready_tag[SUB_LEN +: ID_LEN];

    gon_id_chain #(
        .MASTER_NUMS (MASTER_NUMS),
        .ID_LEN      (ID_LEN)
    ) u_id_chain (
        .clk         (clk),
        .rst         (rst),
        .set_id      (set_id),
        .id_scan_in  (id_scan_in),
        .id_field    (id_field),
        .id_scan_out (id_scan_out),
        .match       (match)
    );

    // The sub field reaches every master unconditionally; only ready is gated by the match.
    generate
        for (genvar gi = 0; gi < MASTER_NUMS; gi++) begin : g_fanout
            if (SUB_LEN > 0) begin : g_sub
                assign master_ready_tag[gi] = {ready & match[gi], ready_tag[SUB_LEN-1:0]};
            end else begin : g_nosub
                assign master_ready_tag[gi] = ready & match[gi];
            end
        end
    endgenerate

    // Scanning from the top down lets the lowest matching index win on multicast.
    always_comb begin
        enable_value = '0;
        for (int i = MASTER_NUMS - 1; i >= 0; i--) begin
            if (ready && match[i]) begin
                enable_value = master_enable_data[i];
            end
        end
    end
endmodule

// File: tb/tb_gon_bus.sv
// Directed and randomized checks of an X-bus style and a Y-bus style gon_bus instance.
module tb_gon_bus;
    localparam int M = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // X-bus style: ID_LEN=5, SUB_LEN=0
    logic [5:0]           x_tag;
    logic [32:0]          x_ev;
    logic [M-1:0][0:0]    x_mrt;
    logic [M-1:0][32:0]   x_med;
    logic                 x_set;
    logic [4:0]           x_sin;
    logic [4:0]           x_sout;

    // Y-bus style: ID_LEN=4, SUB_LEN=5
    logic [9:0]           y_tag;
    logic [32:0]          y_ev;
    logic [M-1:0][5:0]    y_mrt;
    logic [M-1:0][32:0]   y_med;
    logic                 y_set;
    logic [3:0]           y_sin;
    logic [3:0]           y_sout;

    gon_bus #(.MASTER_NUMS(M), .ID_LEN(5), .SUB_LEN(0), .VALUE_LEN(32), .MA_Y(0)) dut_x (
        .clk(clk), .rst(rst), .ready_tag(x_tag), .enable_value(x_ev),
        .master_ready_tag(x_mrt), .master_enable_data(x_med),
        .set_id(x_set), .id_scan_in(x_sin), .id_scan_out(x_sout)
    );

    gon_bus #(.MASTER_NUMS(M), .ID_LEN(4), .SUB_LEN(5), .VALUE_LEN(32), .MA_Y(1)) dut_y (
        .clk(clk), .rst(rst), .ready_tag(y_tag), .enable_value(y_ev),
        .master_ready_tag(y_mrt), .master_enable_data(y_med),
        .set_id(y_set), .id_scan_in(y_sin), .id_scan_out(y_sout)
    );

    // Reference model: the ID each master currently holds.
    logic [4:0] x_ids [M];
    logic [3:0] y_ids [M];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_x(input string tag);
        logic [M-1:0] er;
        logic [32:0]  ev;
        bit           found;
        er = '0; ev = '0; found = 0;
        for (int i = 0; i < M; i++) begin
            if (x_tag[5] && x_ids[i] == x_tag[4:0]) begin
                er[i] = 1'b1;
                if (!found) begin
                    ev = x_med[i];
                    found = 1;
                end
            end
        end
        chk({tag, ".xrdy"}, 64'(x_mrt), 64'(er));
        chk({tag, ".xval"}, 64'(x_ev), 64'(ev));
        chk({tag, ".xsout"}, 64'(x_sout), 64'(x_ids[M-1]));
    endtask

    task automatic check_y(input string tag);
        logic [M-1:0][5:0] er;
        logic [32:0]       ev;
        bit                found;
        ev = '0; found = 0;
        for (int i = 0; i < M; i++) begin
            er[i] = {1'b0, y_tag[4:0]};
            if (y_tag[9] && y_ids[i] == y_tag[8:5]) begin
                er[i][5] = 1'b1;
                if (!found) begin
                    ev = y_med[i];
                    found = 1;
                end
            end
        end
        chk({tag, ".yrdy"}, 64'(y_mrt), 64'(er));
        chk({tag, ".yval"}, 64'(y_ev), 64'(ev));
        chk({tag, ".ysout"}, 64'(y_sout), 64'(y_ids[M-1]));
    endtask

    task automatic shift_x(input logic [4:0] w);
        x_sin = w;
        x_set = 1'b1;
        @(posedge clk);
        #1;
        x_set = 1'b0;
        for (int i = M - 1; i > 0; i--) x_ids[i] = x_ids[i-1];
        x_ids[0] = w;
    endtask

    task automatic shift_y(input logic [3:0] w);
        y_sin = w;
        y_set = 1'b1;
        @(posedge clk);
        #1;
        y_set = 1'b0;
        for (int i = M - 1; i > 0; i--) y_ids[i] = y_ids[i-1];
        y_ids[0] = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < M; i++) begin
            x_ids[i] = '0;
            y_ids[i] = '0;
        end
    endtask

    initial begin
        rst = 1'b1;
        x_tag = '0; x_med = '0; x_set = 1'b0; x_sin = '0;
        y_tag = '0; y_med = '0; y_set = 1'b0; y_sin = '0;
        for (int i = 0; i < M; i++) x_med[i] = {1'b1, 32'(32'h100 + i)};
        do_reset();

        // Reset state: all IDs 0, tag 0 with ready matches every master.
        chk("rst.xsout", 64'(x_sout), 64'd0);
        chk("rst.ysout", 64'(y_sout), 64'd0);
        x_tag = {1'b1, 5'd0};
        #1;
        chk("rst.all_ready", 64'(x_mrt), 64'hF);
        check_x("rst");

        // Scan 3,2,1,0 -> IDs 0,1,2,3.
        x_tag = '0;
        shift_x(5'd3); shift_x(5'd2); shift_x(5'd1); shift_x(5'd0);
        for (int t = 0; t < M; t++) begin
            x_tag = {1'b1, 5'(t)};
            #1;
            chk("scan.onehot", 64'(x_mrt), 64'(4'b0001 << t));
        end
        chk("scan.sout_pre", 64'(x_sout), 64'd3);
        shift_x(5'd7);
        chk("scan.sout_post", 64'(x_sout), 64'd2);
        x_tag = {1'b1, 5'd7};
        #1;
        chk("scan.id0_is7", 64'(x_mrt), 64'b0001);
        check_x("scan5");

        // Unicast, IDs 0,1,2,3.
        shift_x(5'd3); shift_x(5'd2); shift_x(5'd1); shift_x(5'd0);
        x_med[2] = {1'b1, 32'hDEADBEEF};
        x_tag = {1'b1, 5'd2};
        #1;
        chk("uni.rdy", 64'(x_mrt), 64'b0100);
        chk("uni.val", 64'(x_ev), 64'h1_DEADBEEF);
        check_x("uni");

        // Multicast priority, IDs 4,4,9,4.
        shift_x(5'd4); shift_x(5'd9); shift_x(5'd4); shift_x(5'd4);
        x_med[0] = {1'b1, 32'h11};
        x_med[3] = {1'b1, 32'h33};
        x_tag = {1'b1, 5'd4};
        #1;
        chk("multi.rdy", 64'(x_mrt), 64'b1011);
        chk("multi.val", 64'(x_ev), 64'h1_00000011);
        check_x("multi");

        // No match and idle.
        x_tag = {1'b1, 5'd31};
        #1;
        chk("nomatch.rdy", 64'(x_mrt), 64'd0);
        chk("nomatch.val", 64'(x_ev), 64'd0);
        x_tag = {1'b0, 5'd4};
        #1;
        chk("idle.rdy", 64'(x_mrt), 64'd0);
        chk("idle.val", 64'(x_ev), 64'd0);

        // Y-bus pass-through: IDs 0,1,2,3; row 3, col 17.
        shift_y(4'd3); shift_y(4'd2); shift_y(4'd1); shift_y(4'd0);
        y_med[3] = {1'b1, 32'hCAFE0003};
        y_tag = {1'b1, 4'd3, 5'd17};
        #1;
        chk("pass.m3", 64'(y_mrt[3]), 64'(6'b1_10001));
        chk("pass.m0", 64'(y_mrt[0]), 64'(6'b0_10001));
        chk("pass.m1", 64'(y_mrt[1]), 64'(6'b0_10001));
        chk("pass.m2", 64'(y_mrt[2]), 64'(6'b0_10001));
        chk("pass.val", 64'(y_ev), 64'h1_CAFE0003);
        check_y("pass");

        // Randomized traffic, with occasional shifts between requests.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) shift_x(5'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) shift_y(4'($urandom_range(0, 5)));
            for (int i = 0; i < M; i++) begin
                x_med[i] = {1'($urandom), 32'($urandom)};
                y_med[i] = {1'($urandom), 32'($urandom)};
            end
            x_tag = {1'($urandom_range(0, 4) != 0), 5'($urandom_range(0, 8))};
            y_tag = {1'($urandom_range(0, 4) != 0), 4'($urandom_range(0, 6)), 5'($urandom)};
            #1;
            check_x("rand");
            check_y("rand");
        end

        // Reset mid-shift: rst wins over set_id.
        shift_x(5'd5); shift_x(5'd6);
        shift_y(4'd5); shift_y(4'd6);
        rst = 1'b1;
        x_set = 1'b1; x_sin = 5'd9;
        y_set = 1'b1; y_sin = 4'd9;
        @(posedge clk);
        #1;
        rst = 1'b0; x_set = 1'b0; y_set = 1'b0;
        for (int i = 0; i < M; i++) begin
            x_ids[i] = '0;
            y_ids[i] = '0;
        end
        chk("rstmid.xsout", 64'(x_sout), 64'd0);
        chk("rstmid.ysout", 64'(y_sout), 64'd0);
        x_tag = {1'b1, 5'd0};
        y_tag = {1'b1, 4'd0, 5'd3};
        #1;
        chk("rstmid.xall", 64'(x_mrt), 64'hF);
        check_x("rstmid");
        check_y("rstmid");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gon_bus.md
# gon_bus

Single-level bus of the global output network (GON), instantiated twice per array. As the Y-bus, it fans a row-tagged request from the output buffer to the X-buses. As an X-bus, it fans a column-tagged request to the PEs. Each master port holds a scan-configured ID: the slave's `ready` reaches only the masters whose ID matches the tag field, and the matching master's enable/data is returned to the slave combinationally.

## Interface
Parameters:
- `MASTER_NUMS`, 14: master ports (Y-bus: number of X-buses, 12; X-bus: PEs per row, 14).
- `ID_LEN`, 5: width of the per-master ID and of the matched tag field (Y-bus: `ROW_LEN`=4; X-bus: col width 5).
- `SUB_LEN`, 0: tag bits passed through to masters (Y-bus: col width 5; X-bus: 0).
- `VALUE_LEN`, 32: data width.
- `MA_Y`, 0: instance index; used only in simulation messages.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `ready_tag` in `ID_LEN+SUB_LEN+1`: {ready, id_field, sub_field}, MSB = ready.
- `enable_value` out `VALUE_LEN+1`: {enable, value}, MSB = enable.
- `master_ready_tag` out, array `[MASTER_NUMS-1:0]` of `SUB_LEN+1`: {ready_i, sub_field}.
- `master_enable_data` in, array `[MASTER_NUMS-1:0]` of `VALUE_LEN+1`: {enable_i, data_i}.
- `set_id` in 1: shift enable for the ID scan chain.
- `id_scan_in` in `ID_LEN`: scan chain input.
- `id_scan_out` out `ID_LEN`: scan chain output (last ID register).

## Operation
- ID registers: `id_reg[0..MASTER_NUMS-1]`, each `ID_LEN` bits, reset to 0.
- On a rising edge with `set_id`=1 and `rst`=0:
  - `id_reg[0]` ← `id_scan_in`;
  - `id_reg[i]` ← `id_reg[i-1]` for i ≥ 1.
  - Consequence: after N shift cycles, the first word shifted in sits in master N-1.
- `id_scan_out` = `id_reg[MASTER_NUMS-1]`. Chaining instances' scan ports forms one long chain.
- Match: `match[i]` = (`id_reg[i]` == id_field). Several masters may match (multicast).
- Request fan-out, per master i: ready_i = ready & match[i]; its sub_field output is the slave's sub_field, always passed through regardless of match.
- Response gather:
  - If ready=1 and at least one master matches, `enable_value` = `master_enable_data[k]`, where k is the lowest-index matching master.
  - Otherwise `enable_value` = 0.
- Simulation only: when ready=1, display the `MA_Y` instance index and the tag. This must not affect synthesis.

## Timing
- Fan-out and gather are purely combinational: zero-cycle latency from `ready_tag` to `master_ready_tag`, and from `master_enable_data` to `enable_value`.
- Two stacked instances (Y over X) are therefore also zero-latency end to end.
- An ID change is visible on the match logic in the cycle after the shifting edge.
- `rst` has priority over `set_id`. Reset mid-shift clears all IDs to 0, and `id_scan_out` = 0 the cycle after.
- Reset values:
  - `id_scan_out` = 0.
  - All other outputs are combinational. With all IDs 0, a tag of 0 with ready=1 matches every master.
- `set_id` held during traffic is legal: matching uses the current register values.

## Structure
- Package `gon_pkg`: default widths (`ROW_LEN`=4, `COL_LEN`=5, `VALUE_LEN`=32, `XBUS_NUMS`=12, `PE_NUMS`=14).
- Sub-module `gon_id_chain`: the scan shift register plus the per-master comparators (outputs a `match` vector).
- `gon_bus` = `gon_id_chain` + fan-out + priority gather mux.
- `SUB_LEN`=0 must be handled with a generate branch that emits no sub_field slice.

## Test plan
- Scan: `MASTER_NUMS`=4, `ID_LEN`=5, shift in 3,2,1,0 over 4 cycles with `set_id`=1 → IDs [0..3]=0,1,2,3. A fifth shift of 7 gives `id_scan_out`=3 before that edge, and after it IDs [0..3]=7,0,1,2 with `id_scan_out`=2.
- Unicast: IDs 0,1,2,3; `ready_tag`={1,5'd2}; master 2 drives {1,32'hDEADBEEF} → only master 2 ready=1, and `enable_value`=33'h1_DEADBEEF in the same cycle.
- Multicast priority: IDs 4,4,9,4; tag 4, ready=1 → masters 0, 1 and 3 ready. Master 0 drives {1,32'h11} and master 3 drives {1,32'h33} → `enable_value`={1,32'h11}.
- No match / idle:
  - tag 31 with ready=1 → all master ready=0 and `enable_value`=0;
  - ready=0 with a matching tag → `enable_value`=0.
- Pass-through, Y-bus config (`ID_LEN`=4, `SUB_LEN`=5): row 3, col 17, ready=1 → the master with ID 3 receives {1,5'd17}; the others receive {0,5'd17}.
- Reset mid-shift: after 2 shift cycles, assert `rst` together with `set_id` → next cycle all IDs = 0 and `id_scan_out`=0.
